// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: PC walker with I-cache/memory fetch, next-PC pre-decode and an FQ_DEPTH-entry decode FIFO.
// Optional build macro IFQ_PERF_CNT_EN adds saturating hit/miss/flush performance counters.
module inst_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                FQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic [ADDR_W-1:0] clr_pc_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_done_in,
  input  logic [INST_W-1:0] mem_inst_in,
  output logic [ADDR_W-1:0] ic_pc_out,
  input  logic              ic_hit_in,
  input  logic [INST_W-1:0] ic_inst_in,
  output logic              ic_fill_out,
  output logic [ADDR_W-1:0] ic_fill_pc_out,
  output logic [INST_W-1:0] ic_fill_inst_out,
  output logic [ADDR_W-1:0] pr_pc_out,
  input  logic              pr_taken_in,
`ifdef IFQ_PERF_CNT_EN
  output logic [31:0]       perf_hit_out,
  output logic [31:0]       perf_miss_out,
  output logic [31:0]       perf_flush_out,
`endif
  output logic              dq_valid_out,
  input  logic              dq_ready_in,
  output logic [ADDR_W-1:0] dq_pc_out,
  output logic [INST_W-1:0] dq_inst_out,
  output logic [6:0]        dq_op_out,
  output logic              dq_pred_out
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef enum logic [1:0] {IDLE, MEM_WAIT, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] q_pc   [FQ_DEPTH];
  logic [INST_W-1:0] q_inst [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] q_pred;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [INST_W-1:0] fetch_word;
  logic [ADDR_W-1:0] j_imm, b_imm, npc;
  logic              pred;
  logic              q_full, hit_push, mem_push, push, pop;

  // Immediates are sign-extended to the address width so PC sums wrap naturally.
  assign j_imm = {{(ADDR_W-21){fetch_word[31]}}, fetch_word[31], fetch_word[19:12],
                  fetch_word[20], fetch_word[30:21], 1'b0};
  assign b_imm = {{(ADDR_W-13){fetch_word[31]}}, fetch_word[31], fetch_word[7],
                  fetch_word[30:25], fetch_word[11:8], 1'b0};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    fetch_word = (state == MEM_WAIT) ? mem_inst_in : ic_inst_in;
    npc        = pc + ADDR_W'(4);
    pred       = pr_taken_in;
    case (fetch_word[6:0])
      OP_JAL: begin
        npc  = pc + j_imm;
        pred = 1'b1;
      end
      OP_JALR: pred = 1'b0;
      OP_BR:   if (pr_taken_in) npc = pc + b_imm;
      default: ;
    endcase
  end

  assign q_full   = (count == CNT_W'(FQ_DEPTH));
  assign hit_push = (state == IDLE) && !q_full && ic_hit_in;
  assign mem_push = (state == MEM_WAIT) && mem_done_in;
  assign push     = hit_push || mem_push;
  assign pop      = dq_valid_out && dq_ready_in;

  // NOTE: control state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      ic_fill_out      <= 1'b0;
      ic_fill_pc_out   <= '0;
      ic_fill_inst_out <= '0;
    end else if (rdy_in) begin
      ic_fill_out <= 1'b0;
      if (clr_in) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        pc     <= clr_pc_in;
        // An outstanding memory request cannot be cancelled; its response must be swallowed.
        if (state == IDLE) state <= IDLE;
        else               state <= mem_done_in ? IDLE : DRAIN;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          pc     <= npc;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
        case (state)
          IDLE:     if (!q_full && !ic_hit_in) state <= MEM_WAIT;
          MEM_WAIT: if (mem_done_in) begin
            state            <= IDLE;
            ic_fill_out      <= 1'b1;
            ic_fill_pc_out   <= pc;
            ic_fill_inst_out <= mem_inst_in;
          end
          DRAIN:    if (mem_done_in) state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: queue storage has no reset; count gates dq_valid_out so stale entries are never consumed.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clr_in && push) begin
      q_pc[wr_ptr]   <= pc;
      q_inst[wr_ptr] <= fetch_word;
      q_pred[wr_ptr] <= pred;
    end
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_hit_out   <= '0;
      perf_miss_out  <= '0;
      perf_flush_out <= '0;
    end else if (rdy_in) begin
      if (!clr_in && hit_push && perf_hit_out != '1)  perf_hit_out  <= perf_hit_out + 32'd1;
      if (!clr_in && mem_push && perf_miss_out != '1) perf_miss_out <= perf_miss_out + 32'd1;
      if (clr_in && perf_flush_out != '1)             perf_flush_out <= perf_flush_out + 32'd1;
    end
  end
`endif

  assign mem_req_out  = (state == MEM_WAIT);
  assign mem_addr_out = pc;
  assign ic_pc_out    = pc;
  assign pr_pc_out    = pc;
  assign dq_valid_out = (count != '0);
  assign dq_pc_out    = q_pc[rd_ptr];
  assign dq_inst_out  = q_inst[rd_ptr];
  assign dq_op_out    = q_inst[rd_ptr][6:0];
  assign dq_pred_out  = q_pred[rd_ptr];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model checked every cycle plus directed literal expectations.
module tb_inst_fetch_queue;

  localparam int          ADDR_W   = 32;
  localparam int          INST_W   = 32;
  localparam int          FQ_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_in      = 1'b0;
  logic        rst_n_in    = 1'b0;
  logic        rdy_in      = 1'b1;
  logic        clr_in      = 1'b0;
  logic [31:0] clr_pc_in   = '0;
  logic        mem_done_in = 1'b0;
  logic [31:0] mem_inst_in = '0;
  logic        ic_hit_in   = 1'b0;
  logic [31:0] ic_inst_in  = '0;
  logic        pr_taken_in = 1'b0;
  logic        dq_ready_in = 1'b0;

  logic        mem_req_out, ic_fill_out, dq_valid_out, dq_pred_out;
  logic [31:0] mem_addr_out, ic_pc_out, ic_fill_pc_out, ic_fill_inst_out, pr_pc_out;
  logic [31:0] dq_pc_out, dq_inst_out;
  logic [6:0]  dq_op_out;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_hit_out, perf_miss_out, perf_flush_out;
`endif

  inst_fetch_queue #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clr_in(clr_in), .clr_pc_in(clr_pc_in),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
    .mem_done_in(mem_done_in), .mem_inst_in(mem_inst_in),
    .ic_pc_out(ic_pc_out), .ic_hit_in(ic_hit_in), .ic_inst_in(ic_inst_in),
    .ic_fill_out(ic_fill_out), .ic_fill_pc_out(ic_fill_pc_out), .ic_fill_inst_out(ic_fill_inst_out),
    .pr_pc_out(pr_pc_out), .pr_taken_in(pr_taken_in),
`ifdef IFQ_PERF_CNT_EN
    .perf_hit_out(perf_hit_out), .perf_miss_out(perf_miss_out), .perf_flush_out(perf_flush_out),
`endif
    .dq_valid_out(dq_valid_out), .dq_ready_in(dq_ready_in), .dq_pc_out(dq_pc_out),
    .dq_inst_out(dq_inst_out), .dq_op_out(dq_op_out), .dq_pred_out(dq_pred_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of fetched entries, a PC, and two flags for the memory side.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc        = RESET_PC;
  bit          m_waiting   = 1'b0;
  bit          m_discard   = 1'b0;
  bit          m_fill      = 1'b0;
  logic [31:0] m_fill_pc   = '0;
  logic [31:0] m_fill_inst = '0;
  int          m_sz;
  bit          m_do_pop, m_do_push;
  entry_t      m_e;
  logic [32:0] m_r;

  // Returns {predicted_taken, next_pc} from the RISC-V control-flow rules.
  function automatic logic [32:0] model_next(input logic [31:0] pc, input logic [31:0] w, input logic taken);
    int   imm;
    logic p;
    imm = 4;
    p   = taken;
    if (w[6:0] == 7'h6F) begin
      imm = (w[31] ? -(1 << 20) : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
      p   = 1'b1;
    end else if (w[6:0] == 7'h67) begin
      p = 1'b0;
    end else if (w[6:0] == 7'h63 && taken) begin
      imm = (w[31] ? -(1 << 12) : 0) + (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1);
    end
    return {p, pc + 32'(imm)};
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_q.delete();
      m_pc      = RESET_PC;
      m_waiting = 1'b0;
      m_discard = 1'b0;
      m_fill    = 1'b0;
      m_fill_pc = '0;
      m_fill_inst = '0;
    end else if (rdy_in) begin
      m_fill = 1'b0;
      if (clr_in) begin
        m_q.delete();
        m_pc = clr_pc_in;
        m_discard = (m_waiting || m_discard) && !mem_done_in;
        m_waiting = 1'b0;
      end else begin
        m_sz      = m_q.size();
        m_do_pop  = (m_sz != 0) && dq_ready_in;
        m_do_push = 1'b0;
        if (m_waiting) begin
          if (mem_done_in) begin
            m_r         = model_next(m_pc, mem_inst_in, pr_taken_in);
            m_e         = '{m_pc, mem_inst_in, m_r[32]};
            m_do_push   = 1'b1;
            m_fill      = 1'b1;
            m_fill_pc   = m_pc;
            m_fill_inst = mem_inst_in;
            m_pc        = m_r[31:0];
            m_waiting   = 1'b0;
          end
        end else if (m_discard) begin
          if (mem_done_in) m_discard = 1'b0;
        end else if (m_sz < FQ_DEPTH) begin
          if (ic_hit_in) begin
            m_r       = model_next(m_pc, ic_inst_in, pr_taken_in);
            m_e       = '{m_pc, ic_inst_in, m_r[32]};
            m_do_push = 1'b1;
            m_pc      = m_r[31:0];
          end else begin
            m_waiting = 1'b1;
          end
        end
        if (m_do_pop)  void'(m_q.pop_front());
        if (m_do_push) m_q.push_back(m_e);
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      check("mem_req", mem_req_out, m_waiting);
      check("mem_addr", mem_addr_out, m_pc);
      check("ic_pc", ic_pc_out, m_pc);
      check("pr_pc", pr_pc_out, m_pc);
      check("dq_valid", dq_valid_out, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("dq_pc", dq_pc_out, m_q[0].pc);
        check("dq_inst", dq_inst_out, m_q[0].inst);
        check("dq_op", dq_op_out, m_q[0].inst[6:0]);
        check("dq_pred", dq_pred_out, m_q[0].pred);
      end
      check("ic_fill", ic_fill_out, m_fill);
      if (m_fill) begin
        check("ic_fill_pc", ic_fill_pc_out, m_fill_pc);
        check("ic_fill_inst", ic_fill_inst_out, m_fill_inst);
      end
    end else begin
      check("rst dq_valid", dq_valid_out, 1'b0);
      check("rst mem_req", mem_req_out, 1'b0);
      check("rst ic_fill", ic_fill_out, 1'b0);
    end
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    ticks(2);
    check("reset dq_valid", dq_valid_out, 1'b0);
    check("reset mem_req", mem_req_out, 1'b0);
    check("reset ic_pc", ic_pc_out, RESET_PC);
    check("reset ic_fill", ic_fill_out, 1'b0);
    rst_n_in = 1'b1;

    // 1: miss from reset, memory fill, next miss at pc+4
    tick();
    check("t1 mem_req", mem_req_out, 1'b1);
    check("t1 mem_addr", mem_addr_out, 32'h0);
    mem_done_in = 1'b1; mem_inst_in = 32'h0000_0013;
    tick();
    mem_done_in = 1'b0;
    check("t1 fill", ic_fill_out, 1'b1);
    check("t1 fill_pc", ic_fill_pc_out, 32'h0);
    check("t1 fill_inst", ic_fill_inst_out, 32'h13);
    check("t1 dq_valid", dq_valid_out, 1'b1);
    check("t1 dq_pc", dq_pc_out, 32'h0);
    tick();
    check("t1 next mem_addr", mem_addr_out, 32'h4);
    check("t1 fill pulse ends", ic_fill_out, 1'b0);
    mem_done_in = 1'b1;
    tick();
    mem_done_in = 1'b0;

    // 2: JAL +8 at 0x100
    clr_in = 1'b1; clr_pc_in = 32'h100;
    tick();
    check("t2 flushed", dq_valid_out, 1'b0);
    check("t2 redirect", ic_pc_out, 32'h100);
    clr_in = 1'b0; ic_hit_in = 1'b1; ic_inst_in = 32'h0080_006F;
    tick();
    check("t2 dq_pred", dq_pred_out, 1'b1);
    check("t2 dq_op", dq_op_out, 7'h6F);
    check("t2 next pc", ic_pc_out, 32'h108);

    // 3: BEQ -16 at 0x200, taken then not taken
    ic_hit_in = 1'b0; clr_in = 1'b1; clr_pc_in = 32'h200;
    tick();
    clr_in = 1'b0; ic_hit_in = 1'b1; ic_inst_in = 32'hFE00_08E3; pr_taken_in = 1'b1;
    tick();
    check("t3 taken pc", ic_pc_out, 32'h1F0);
    check("t3 taken pred", dq_pred_out, 1'b1);
    ic_hit_in = 1'b0; clr_in = 1'b1; clr_pc_in = 32'h200;
    tick();
    clr_in = 1'b0; ic_hit_in = 1'b1; pr_taken_in = 1'b0;
    tick();
    check("t3 not-taken pc", ic_pc_out, 32'h204);
    check("t3 not-taken pred", dq_pred_out, 1'b0);

    // 4: fill to FQ_DEPTH, one pop then one refill
    ic_hit_in = 1'b0; clr_in = 1'b1; clr_pc_in = 32'h300;
    tick();
    clr_in = 1'b0; ic_hit_in = 1'b1; ic_inst_in = 32'h0000_0013;
    ticks(6);
    check("t4 head", dq_pc_out, 32'h300);
    check("t4 pc frozen", ic_pc_out, 32'h310);
    dq_ready_in = 1'b1;
    tick();
    dq_ready_in = 1'b0;
    check("t4 popped head", dq_pc_out, 32'h304);
    tick();
    check("t4 refill", ic_pc_out, 32'h314);
    tick();
    check("t4 full again", ic_pc_out, 32'h314);

    // rdy_in low freezes pop and redirect
    rdy_in = 1'b0; dq_ready_in = 1'b1; clr_in = 1'b1; clr_pc_in = 32'h999;
    ticks(2);
    check("rdy freeze head", dq_pc_out, 32'h304);
    check("rdy freeze pc", ic_pc_out, 32'h314);
    rdy_in = 1'b1; dq_ready_in = 1'b0; clr_in = 1'b0;

    // 5: redirect during MEM_WAIT, late response dropped
    ic_hit_in = 1'b0; clr_in = 1'b1; clr_pc_in = 32'h500;
    tick();
    clr_in = 1'b0;
    tick();
    check("t5 mem_req", mem_req_out, 1'b1);
    check("t5 mem_addr", mem_addr_out, 32'h500);
    clr_in = 1'b1; clr_pc_in = 32'h400;
    tick();
    clr_in = 1'b0;
    check("t5 drain req", mem_req_out, 1'b0);
    tick();
    mem_done_in = 1'b1; mem_inst_in = 32'h0000_0013;
    tick();
    mem_done_in = 1'b0;
    check("t5 no fill", ic_fill_out, 1'b0);
    check("t5 no push", dq_valid_out, 1'b0);
    tick();
    check("t5 new req", mem_req_out, 1'b1);
    check("t5 new addr", mem_addr_out, 32'h400);

    // 6: async reset mid MEM_WAIT with two entries queued
    mem_done_in = 1'b1;
    tick();
    mem_done_in = 1'b0;
    tick();
    mem_done_in = 1'b1;
    tick();
    mem_done_in = 1'b0;
    tick();
    check("t6 waiting", mem_req_out, 1'b1);
    check("t6 queued head", dq_pc_out, 32'h400);
    #2 rst_n_in = 1'b0;
    #1;
    check("t6 async dq_valid", dq_valid_out, 1'b0);
    check("t6 async mem_req", mem_req_out, 1'b0);
    check("t6 async pc", ic_pc_out, RESET_PC);
    tick();
    rst_n_in = 1'b1;
    tick();
    check("t6 restart addr", mem_addr_out, RESET_PC);
    check("t6 restart req", mem_req_out, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
